// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle unsigned multiply/divide unit that owns the
//               architectural HI/LO registers. Handles one bit per cycle
//               (shift-add multiply, restoring divide) on private working
//               registers, so HI/LO keep the previous result until done.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               start, op, opA, opB - request (op 0 = multu, 1 = divu)
//               hi_we, lo_we, wdata - mthi / mtlo writes (idle only)
//               busy, done          - handshake status
//               div_by_zero         - divu had a zero divisor (valid w/ done)
//               hi, lo              - architectural HI / LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [5:0] c_last_iter = 6'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;

    // Working registers: r_acc is the upper half of the product or the
    // partial remainder; r_q is the lower half of the product or the quotient.
    logic             r_op;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [5:0]       r_count;

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_dbz;

    logic             w_start_acc;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_diff;

    assign w_start_acc = start && (r_state == S_IDLE);

    // Multiply step: conditional add into the upper half, carry kept in bit WIDTH.
    assign w_mul_sum   = {1'b0, r_acc} + {1'b0, (r_q[0] ? r_operand : {WIDTH{1'b0}})};

    // Divide step: the shifted remainder can be WIDTH+1 bits wide, but when the
    // trial subtraction succeeds the difference is below the divisor, so a
    // WIDTH-bit subtraction is exact.
    assign w_div_shift = {r_acc, r_q[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_operand});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_operand;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_RUN;
            S_RUN:    if (r_count == c_last_iter) w_state_next = S_FINISH;
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Working datapath; no reset needed since every operation reloads it.
    always_ff @(posedge clk) begin
        if (w_start_acc) begin
            r_op      <= op;
            r_operand <= opB;
            r_acc     <= '0;
            r_q       <= opA;
            r_count   <= '0;
        end else if (r_state == S_RUN) begin
            r_count <= r_count + 6'd1;
            if (r_op) begin
                r_acc <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
                r_q   <= {r_q[WIDTH-2:0], w_div_ge};
            end else begin
                r_acc <= w_mul_sum[WIDTH:1];
                r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
            end
        end
    end

    // Architectural state. HI/LO writes from mthi/mtlo are only honoured when
    // idle and not simultaneously accepting a new request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= (r_state == S_FINISH);
            if (r_state == S_FINISH) begin
                r_hi  <= r_acc;
                r_lo  <= r_q;
                r_dbz <= r_op && (r_operand == '0);
            end else if (w_start_acc) begin
                r_dbz <= 1'b0;
            end else if (r_state == S_IDLE) begin
                if (hi_we) r_hi <= wdata;
                if (lo_we) r_lo <= wdata;
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit (WIDTH = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;   // edges since the accepting edge (edge 0)

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .opA         (opA),
        .opB         (opB),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present a request and step through the accepting edge (edge 0).
    task automatic start_op(input logic o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start = 1'b1;
        op    = o;
        opA   = a;
        opB   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
    endtask

    // Wait (bounded) for done; busy must hold until then, latency must be 33.
    task automatic wait_done(input string tag, input logic [WIDTH-1:0] eh,
                             input logic [WIDTH-1:0] el, input logic edbz);
        while (done !== 1'b1 && cyc < 40) begin
            check({tag, "_busy"}, 64'(busy), 64'(1'b1));
            step();
        end
        check({tag, "_latency"}, 64'(cyc), 64'(WIDTH + 1));
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(edbz));
        check({tag, "_busy_low"}, 64'(busy), 64'(1'b0));
    endtask

    int pulses;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        opA   = '0;
        opB   = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_done", 64'(done), 64'(1'b0));
        check("rst_hi",   64'(hi),   64'(0));
        check("rst_lo",   64'(lo),   64'(0));
        check("rst_dbz",  64'(div_by_zero), 64'(1'b0));

        // multu 7 * 6
        start_op(1'b0, 32'd7, 32'd6);
        wait_done("mul7x6", 32'h0, 32'h2A, 1'b0);
        step();
        check("mul7x6_done_1cyc", 64'(done), 64'(1'b0));

        // multu max * max, then divu 100/7 issued in the done cycle
        start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mulmax", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        start_op(1'b1, 32'd100, 32'd7);
        wait_done("div100_7", 32'd2, 32'd14, 1'b0);

        // divu by zero
        start_op(1'b1, 32'h1234_5678, 32'h0);
        wait_done("divzero", 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        step();
        check("divzero_dbz_hold", 64'(div_by_zero), 64'(1'b1));

        // mthi / mtlo while idle
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        step();
        hi_we = 1'b0;
        check("mthi", 64'(hi), 64'(32'hDEAD_BEEF));
        lo_we = 1'b1;
        wdata = 32'h0BAD_F00D;
        step();
        lo_we = 1'b0;
        check("mtlo", 64'(lo), 64'(32'h0BAD_F00D));
        check("mtlo_hi_kept", 64'(hi), 64'(32'hDEAD_BEEF));

        // writes while busy are ignored; result then overwrites HI/LO
        start_op(1'b0, 32'd2, 32'd3);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h1111_1111;
        step();
        step();
        step();
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("busywr_hi", 64'(hi), 64'(32'hDEAD_BEEF));
        check("busywr_lo", 64'(lo), 64'(32'h0BAD_F00D));
        wait_done("mul2x3", 32'h0, 32'd6, 1'b0);

        // second start at edge 10 is ignored
        step();
        start_op(1'b0, 32'd9, 32'd9);
        while (cyc < 9) step();
        start = 1'b1;
        op    = 1'b1;
        opA   = 32'd50;
        opB   = 32'd5;
        step();
        start = 1'b0;
        wait_done("mul9x9", 32'h0, 32'd81, 1'b0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        check("ignored_start_no_2nd_done", 64'(pulses), 64'(0));

        // reset at edge 15 of a divu
        start_op(1'b1, 32'd1000, 32'd3);
        while (cyc < 14) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'(1'b0));
        check("midrst_hi",   64'(hi),   64'(0));
        check("midrst_lo",   64'(lo),   64'(0));
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        check("midrst_no_done", 64'(pulses), 64'(0));
        start_op(1'b0, 32'd3, 32'd5);
        wait_done("mul3x5", 32'h0, 32'd15, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
